// File: rtl/dunc16_if.sv
// Monitoring bundle exported by dunc16_cpu: accumulator, memory-data register,
// memory read data, current address and the STA write handshake.
interface dunc16_if;
    logic        i_sta;
    logic        setwrite;
    logic        clrwrite;
    logic        write;
    logic        do_write;
    logic [15:0] ac_out;
    logic [15:0] md_out;
    logic [15:0] mmo;
    logic [15:0] address;

    modport master (
        output i_sta, setwrite, clrwrite, write, do_write,
        output ac_out, md_out, mmo, address
    );

    modport slave (
        input i_sta, setwrite, clrwrite, write, do_write,
        input ac_out, md_out, mmo, address
    );
endinterface

// File: rtl/dunc16_cpu.sv
// Multicycle 16-bit accumulator CPU (FETCH/EXEC/COMPLETE) with a 4096x16
// unified program/data memory; asynchronous read, synchronous write.
module dunc16_cpu #(
    parameter string INIT_FILE = ""
) (
    input  logic     clk_i,
    input  logic     rst_n_i,
    dunc16_if.master mon
);
    typedef enum logic [1:0] {
        ST_FETCH    = 2'd0,
        ST_EXEC     = 2'd1,
        ST_COMPLETE = 2'd2,
        ST_HALT     = 2'd3
    } state_e;

    localparam logic [3:0] OP_LDA = 4'h1, OP_STA = 4'h2, OP_ADD = 4'h3, OP_SUB = 4'h4,
                           OP_AND = 4'h5, OP_OR  = 4'h6, OP_XOR = 4'h7, OP_JMP = 4'h8,
                           OP_JZ  = 4'h9, OP_JN  = 4'hA, OP_LDI = 4'hB, OP_NOT = 4'hC,
                           OP_SHL = 4'hD, OP_SHR = 4'hE, OP_HLT = 4'hF;

    state_e      state_q;
    logic [11:0] pc_q;
    logic [15:0] ir_q;
    logic [15:0] ac_q;
    logic [15:0] md_q;
    logic        write_q;

    // Memory keeps its contents across reset; this is the power-up image.
    logic [15:0] mem_q [4096] = '{
        0: 16'h1010, 1: 16'h3011, 2: 16'h2012, 3: 16'hF000,
        16: 16'h0005, 17: 16'h0003, default: 16'h0000
    };

    logic [3:0]  opcode_s;
    logic [11:0] a_s;
    logic [11:0] addr_s;
    logic [15:0] mmo_s;
    logic [15:0] ac_d;
    logic        jump_s;
    logic        i_sta_s;
    logic        setwrite_s;
    logic        clrwrite_s;
    logic        do_write_s;

    assign opcode_s   = ir_q[15:12];
    assign a_s        = ir_q[11:0];
    assign i_sta_s    = (opcode_s == OP_STA);
    assign setwrite_s = (state_q == ST_EXEC) && i_sta_s;
    assign clrwrite_s = (state_q == ST_COMPLETE) && write_q;
    assign do_write_s = (state_q == ST_COMPLETE) && write_q;
    assign mmo_s      = mem_q[addr_s];

    // Address mux: PC while fetching, operand field otherwise.
    always_comb begin
        if (state_q == ST_FETCH) begin
            addr_s = pc_q;
        end else begin
            addr_s = a_s;
        end
    end

    // ALU result; opcodes that leave AC alone pass it through.
    always_comb begin
        ac_d = ac_q;
        case (opcode_s)
            OP_LDA:  ac_d = md_q;
            OP_ADD:  ac_d = ac_q + md_q;
            OP_SUB:  ac_d = ac_q - md_q;
            OP_AND:  ac_d = ac_q & md_q;
            OP_OR:   ac_d = ac_q | md_q;
            OP_XOR:  ac_d = ac_q ^ md_q;
            OP_LDI:  ac_d = {4'h0, a_s};
            OP_NOT:  ac_d = ~ac_q;
            OP_SHL:  ac_d = {ac_q[14:0], 1'b0};
            OP_SHR:  ac_d = {1'b0, ac_q[15:1]};
            default: ac_d = ac_q;
        endcase
    end

    // Branch decision, evaluated against the current accumulator.
    always_comb begin
        jump_s = 1'b0;
        case (opcode_s)
            OP_JMP:  jump_s = 1'b1;
            OP_JZ:   jump_s = (ac_q == 16'h0000);
            OP_JN:   jump_s = ac_q[15];
            default: jump_s = 1'b0;
        endcase
    end

    // Instruction sequencer and architectural registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_FETCH;
            pc_q    <= 12'h000;
            ir_q    <= 16'h0000;
            ac_q    <= 16'h0000;
            md_q    <= 16'h0000;
            write_q <= 1'b0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    ir_q    <= mmo_s;
                    pc_q    <= pc_q + 12'd1;
                    state_q <= ST_EXEC;
                end
                ST_EXEC: begin
                    md_q <= mmo_s;
                    if (jump_s) begin
                        pc_q <= a_s;
                    end
                    if (setwrite_s) begin
                        write_q <= 1'b1;
                    end
                    state_q <= (opcode_s == OP_HLT) ? ST_HALT : ST_COMPLETE;
                end
                ST_COMPLETE: begin
                    ac_q <= ac_d;
                    if (clrwrite_s) begin
                        write_q <= 1'b0;
                    end
                    state_q <= ST_FETCH;
                end
                default: begin
                    state_q <= ST_HALT;
                end
            endcase
        end
    end

    // STA store; gated by state so a reset mid-instruction cancels it.
    always @(posedge clk_i) begin
        if (do_write_s) begin
            mem_q[addr_s] <= ac_q;
        end
    end

    assign mon.i_sta    = i_sta_s;
    assign mon.setwrite = setwrite_s;
    assign mon.clrwrite = clrwrite_s;
    assign mon.write    = write_q;
    assign mon.do_write = do_write_s;
    assign mon.ac_out   = ac_q;
    assign mon.md_out   = md_q;
    assign mon.mmo      = mmo_s;
    assign mon.address  = {4'h0, addr_s};
endmodule

// File: tb/tb_dunc16_cpu.sv
// Directed bench for dunc16_cpu: built-in program, STA handshake, reset abort,
// arithmetic wrap, branches and PC wrap.
module tb_dunc16_cpu;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    dunc16_if mon ();

    dunc16_cpu #(.INIT_FILE("")) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .mon     (mon)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 2 time units past the last one.
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0;
        cycles(2);
        check("rst_ac", mon.ac_out, 16'h0000);
        check("rst_md", mon.md_out, 16'h0000);
        check("rst_addr", mon.address, 16'h0000);
        check("rst_mmo", mon.mmo, 16'h1010);
        check1("rst_write", mon.write, 1'b0);
        check1("rst_setwrite", mon.setwrite, 1'b0);
        check1("rst_ista", mon.i_sta, 1'b0);

        // Built-in program, first pass
        rst_n = 1'b1;
        cycles(1);
        check("c1_addr", mon.address, 16'h0010);
        check("c1_mmo", mon.mmo, 16'h0005);
        cycles(2);
        check("c3_ac", mon.ac_out, 16'h0005);
        cycles(3);
        check("c6_ac", mon.ac_out, 16'h0008);
        check("c6_md", mon.md_out, 16'h0003);
        cycles(1);
        check1("c8_ista", mon.i_sta, 1'b1);
        check1("c8_setwrite", mon.setwrite, 1'b1);
        check1("c8_write", mon.write, 1'b0);
        check1("c8_dowrite", mon.do_write, 1'b0);
        check("c8_addr", mon.address, 16'h0012);
        cycles(1);
        check1("c9_ista", mon.i_sta, 1'b1);
        check1("c9_setwrite", mon.setwrite, 1'b0);
        check1("c9_write", mon.write, 1'b1);
        check1("c9_dowrite", mon.do_write, 1'b1);
        check1("c9_clrwrite", mon.clrwrite, 1'b1);

        // Reset in the middle of the STA COMPLETE cycle aborts the store
        #1;
        rst_n = 1'b0;
        #1;
        check1("abort_write", mon.write, 1'b0);
        check1("abort_dowrite", mon.do_write, 1'b0);
        check1("abort_clrwrite", mon.clrwrite, 1'b0);
        check1("abort_ista", mon.i_sta, 1'b0);
        check("abort_ac", mon.ac_out, 16'h0000);
        check("abort_md", mon.md_out, 16'h0000);
        check("abort_addr", mon.address, 16'h0000);
        check("abort_mmo", mon.mmo, 16'h1010);
        cycles(2);
        check("abort_mem12", dut.mem_q[12'h012], 16'h0000);

        // Full run to HALT
        rst_n = 1'b1;
        cycles(6);
        check("r2_c6_ac", mon.ac_out, 16'h0008);
        cycles(3);
        check("r2_c9_mem12", dut.mem_q[12'h012], 16'h0008);
        check1("r2_c9_write", mon.write, 1'b0);
        check1("r2_c9_clrwrite", mon.clrwrite, 1'b0);
        check("r2_c9_addr", mon.address, 16'h0003);
        cycles(2);
        cycles(40);
        check("halt_pc", {4'h0, dut.pc_q}, 16'h0004);
        check("halt_ac", mon.ac_out, 16'h0008);
        check("halt_addr", mon.address, 16'h0000);
        check1("halt_write", mon.write, 1'b0);
        check1("halt_setwrite", mon.setwrite, 1'b0);

        // Second program: arithmetic wrap, JZ, JN both ways, JMP, PC wrap
        rst_n = 1'b0;
        dut.mem_q[12'h000] = 16'hBFFF;
        dut.mem_q[12'h001] = 16'hD000;
        dut.mem_q[12'h002] = 16'hD000;
        dut.mem_q[12'h003] = 16'hD000;
        dut.mem_q[12'h004] = 16'hD000;
        dut.mem_q[12'h005] = 16'h3020;
        dut.mem_q[12'h006] = 16'h9040;
        dut.mem_q[12'h007] = 16'hF000;
        dut.mem_q[12'h020] = 16'h0010;
        dut.mem_q[12'h021] = 16'h8000;
        dut.mem_q[12'h022] = 16'h7FFF;
        dut.mem_q[12'h040] = 16'h1021;
        dut.mem_q[12'h041] = 16'hA050;
        dut.mem_q[12'h042] = 16'hF000;
        dut.mem_q[12'h050] = 16'h1022;
        dut.mem_q[12'h051] = 16'hA060;
        dut.mem_q[12'h052] = 16'h8FFF;
        dut.mem_q[12'h060] = 16'hF000;
        dut.mem_q[12'hFFF] = 16'h0000;
        cycles(2);
        rst_n = 1'b1;
        cycles(3);
        check("ldi_ac", mon.ac_out, 16'h0FFF);
        cycles(12);
        check("shl4_ac", mon.ac_out, 16'hFFF0);
        cycles(2);
        check("add_md", mon.md_out, 16'h0010);
        cycles(1);
        check("add_wrap_ac", mon.ac_out, 16'h0000);
        cycles(3);
        check("jz_taken_addr", mon.address, 16'h0040);
        cycles(3);
        check("lda_neg_ac", mon.ac_out, 16'h8000);
        cycles(3);
        check("jn_taken_addr", mon.address, 16'h0050);
        cycles(3);
        check("lda_pos_ac", mon.ac_out, 16'h7FFF);
        cycles(3);
        check("jn_fall_addr", mon.address, 16'h0052);
        cycles(3);
        check("jmp_addr", mon.address, 16'h0FFF);
        check("jmp_mmo", mon.mmo, 16'h0000);
        cycles(3);
        check("pcwrap_addr", mon.address, 16'h0000);
        check("pcwrap_mmo", mon.mmo, 16'hBFFF);
        cycles(3);
        check("rerun_ac", mon.ac_out, 16'h0FFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dunc16_cpu.md
# dunc16_cpu

Multicycle 16-bit accumulator processor with a self-contained 4096x16 unified program/data memory. Each instruction executes in a fixed three-state sequence (FETCH, EXEC, COMPLETE). Accumulator, memory-data register, memory output, current address and the write-control handshake are exported for monitoring by the surrounding test and debug logic. Internally it holds PC, IR, AC, MD, a WRITE flag register, a combinational ALU (result `S`) and the memory.

## Interface
Parameters:
- INIT_FILE, "" : hex image loaded into memory at configuration; empty selects the built-in image (see Operation).

Ports:
- CLK  in  1  single system clock; all state changes on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- I_STA  out  1  high while IR decodes as STA (opcode 0x2).
- SETWRITE  out  1  combinational; high in EXEC of STA; sets WRITE.
- CLRWRITE  out  1  combinational; high in COMPLETE when WRITE=1; clears WRITE.
- WRITE  out  1  write-flag register output.
- DO_WRITE  out  1  memory write enable = WRITE AND state==COMPLETE.
- AC_OUT  out  16  accumulator.
- MD_OUT  out  16  memory-data register.
- MMO  out  16  combinational memory read data, mem[ADDRESS].
- ADDRESS  out  16  memory address, {4'b0, 12-bit addr}.

## Operation
- Instruction word: opcode = [15:12], operand A = [11:0].
- Opcodes (M = mem[A]):
  - 0 NOP.
  - 1 LDA: AC<=M.
  - 2 STA: M<=AC.
  - 3 ADD: AC<=AC+M.
  - 4 SUB: AC<=AC-M.
  - 5 AND.
  - 6 OR.
  - 7 XOR.
  - 8 JMP: PC<=A.
  - 9 JZ: PC<=A if AC==0.
  - A JN: PC<=A if AC[15].
  - B LDI: AC<={4'b0,A}.
  - C NOT: AC<=~AC.
  - D SHL: AC<=AC<<1, zero fill.
  - E SHR: AC<=AC>>1, logical.
  - F HLT.
- Arithmetic is mod 2^16; carry and overflow are discarded. No flag registers; JZ/JN test AC directly.
- Memory: asynchronous read, synchronous write of AC on a rising edge when DO_WRITE=1. Contents are not affected by RESET.
- ADDRESS is PC in FETCH, and A in EXEC and COMPLETE.
- States:
  - FETCH: IR<=MMO; PC<=PC+1 (12-bit wrap 0xFFF->0x000); next EXEC.
  - EXEC: MD<=MMO; jumps update PC here; SETWRITE for STA. Next is HALT if opcode F, else COMPLETE.
  - COMPLETE: AC<=ALU S for data-op opcodes; STA memory write; WRITE cleared; next FETCH.
  - HALT: absorbing; only RESET exits.
- ALU S is combinational from AC, MD and opcode; pass-through for opcodes that do not modify AC.
- Built-in image (all other words 0x0000):
  - 0x000: 0x1010 (LDA 0x10)
  - 0x001: 0x3011 (ADD 0x11)
  - 0x002: 0x2012 (STA 0x12)
  - 0x003: 0xF000 (HLT)
  - 0x010: 0x0005
  - 0x011: 0x0003

## Timing
- RESET low (any time, mid-instruction included): immediately PC=0, IR=0, AC=0, MD=0, WRITE=0, state=FETCH. Outputs then read SETWRITE=CLRWRITE=DO_WRITE=I_STA=0, ADDRESS=0x0000, MMO=mem[0]. An in-progress STA write is aborted.
- Release: first rising edge with RESET high performs FETCH.
- Every non-halting instruction takes exactly 3 cycles; throughput 1 instruction per 3 clocks.
- STA handshake:
  - SETWRITE in EXEC -> WRITE=1 from that edge.
  - COMPLETE: DO_WRITE=CLRWRITE=1; memory written and WRITE=0 on the closing edge.
  - WRITE is never high outside COMPLETE.
- SETWRITE and CLRWRITE are never simultaneously high.
- A taken jump takes effect at the end of EXEC; the next FETCH uses the new PC.

## Test plan
- Reset: hold RESET low 2 cycles mid-run -> all registers 0, ADDRESS=0x0000, WRITE=0 immediately, without waiting for a clock edge.
- Built-in program: after release -> AC=0x0005 after cycle 3; AC=0x0008 after cycle 6; mem[0x12]=0x0008 after cycle 9; state HALT from cycle 11 with PC=0x004 held for 40 cycles.
- STA handshake: during the built-in STA -> I_STA=1 over cycles 8-9; SETWRITE=1 in cycle 8 only; WRITE, DO_WRITE and CLRWRITE =1 in cycle 9 only.
- Arithmetic wrap: LDI 0xFFF; SHL x4 -> AC=0xFFF0; ADD of 0x0010 -> AC=0x0000; then JZ taken.
- Branches: JN with AC=0x8000 taken; JN with AC=0x7FFF falls through to PC+1; JMP 0x000 re-runs the program.
- PC wrap: NOP at 0xFFF -> next fetch at 0x000.
